// File: rtl/qq_host_if.sv
// QuickQ host front end: one client op at a time, strobed into the head node.
// Optional watchdog on the WAIT state when QQ_HOST_TIMEOUT_EN is defined.
module qq_host_if #(
    parameter int W = 8,
    parameter int D = 4,
    localparam int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [W-1:0]  req_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_err,
    output logic          q_enq,
    output logic          q_deq,
    output logic          q_repl,
    output logic [W-1:0]  q_data,
    input  logic          q_rdy,
    input  logic          q_full,
    input  logic          q_empty,
    input  logic [W-1:0]  q_top,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ENQ  = 2'b01;
    localparam logic [1:0] OP_DEQ  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    localparam logic [CW-1:0] CNT_MAX = CW'(D);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t     state;
    logic [1:0] op_r;
    logic       go;
    logic       acc_err;

`ifdef QQ_HOST_TIMEOUT_EN
    logic [3:0] wd;
`endif

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Strobes fire combinationally so a reset in ISSUE kills them at once.
    assign go     = (state == ISSUE) && q_rdy;
    assign q_enq  = go && (op_r == OP_ENQ);
    assign q_deq  = go && (op_r == OP_DEQ);
    assign q_repl = go && (op_r == OP_REPL);

    always_comb begin
        acc_err = 1'b0;
        if (req_op == OP_ENQ)
            acc_err = q_full;
        else if (req_op == OP_DEQ || req_op == OP_REPL)
            acc_err = q_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_r     <= OP_NOP;
            q_data   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            count    <= '0;
`ifdef QQ_HOST_TIMEOUT_EN
            wd       <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_r     <= req_op;
                        q_data   <= req_data;
                        rsp_data <= '0;
                        rsp_err  <= acc_err;
                        if (acc_err || req_op == OP_NOP)
                            state <= RESP;
                        else
                            state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (q_rdy) begin
                        // DEQ and REPL both remove the current head key
                        rsp_data <= op_r[1] ? q_top : '0;
                        if (op_r == OP_ENQ && count != CNT_MAX)
                            count <= count + CNT_ONE;
                        else if (op_r == OP_DEQ && count != '0)
                            count <= count - CNT_ONE;
`ifdef QQ_HOST_TIMEOUT_EN
                        wd <= '0;
`endif
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (q_rdy) begin
                        state <= RESP;
`ifdef QQ_HOST_TIMEOUT_EN
                    end else if (wd == 4'hF) begin
                        rsp_err <= 1'b1;
                        state   <= RESP;
                    end else begin
                        wd <= wd + 4'd1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qq_host_if.sv
// Directed bench for qq_host_if: scoreboard of expected responses,
// strobe monitor and immediate-assertion checks.
module tb_qq_host_if;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] ENQ  = 2'b01;
    localparam logic [1:0] DEQ  = 2'b10;
    localparam logic [1:0] REPL = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [W-1:0]  req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic          q_enq;
    logic          q_deq;
    logic          q_repl;
    logic [W-1:0]  q_data;
    logic          q_rdy = 1'b1;
    logic          q_full = 1'b0;
    logic          q_empty = 1'b1;
    logic [W-1:0]  q_top = '0;
    logic [CW-1:0] count;

    int passed = 0;
    int total  = 0;
    int ne = 0;
    int nd = 0;
    int nr = 0;
    int exp_count = 0;

    logic [W:0] sb[$];

    qq_host_if #(.W(W), .D(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .q_enq(q_enq), .q_deq(q_deq), .q_repl(q_repl),
        .q_data(q_data), .q_rdy(q_rdy),
        .q_full(q_full), .q_empty(q_empty), .q_top(q_top),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Strobe monitor: counts strobe cycles and checks exclusivity.
    always @(negedge clk) begin
        ne = ne + int'(q_enq);
        nd = nd + int'(q_deq);
        nr = nr + int'(q_repl);
        if (q_enq || q_deq || q_repl)
            chk("strobe_onehot", {29'd0, q_enq, q_deq, q_repl} & ({29'd0, q_enq, q_deq, q_repl} - 1), 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_strobes"}, {q_enq, q_deq, q_repl}, 0);
        chk({tag, "_q_data"}, q_data, 0);
        chk({tag, "_count"}, count, 0);
    endtask

    // One full transaction; called at posedge+1 with DUT idle.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] data,
                          input logic [W-1:0] top, input logic full,
                          input logic empty, input int rdy_hold,
                          input int rsp_hold);
        logic          e_err;
        logic          issue;
        logic [W-1:0]  e_data;
        logic [W:0]    e;
        int            n;
        e_err  = (op == ENQ && full) || ((op == DEQ || op == REPL) && empty);
        issue  = !e_err && op != NOP;
        e_data = (issue && (op == DEQ || op == REPL)) ? top : '0;
        sb.push_back({e_err, e_data});
        if (issue && op == ENQ && exp_count < D) exp_count++;
        if (issue && op == DEQ && exp_count > 0) exp_count--;
        ne = 0; nd = 0; nr = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        q_full    = full;
        q_empty   = empty;
        q_top     = top;
        q_rdy     = (rdy_hold == 0);
        chk("accept_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        q_full    = 1'b0;
        q_empty   = 1'b0;
        chk("q_data", q_data, data);
        if (issue) begin
            chk("issue_no_rsp", rsp_valid, 0);
            for (int i = 0; i < rdy_hold; i++) begin
                chk("stall_no_strobe", {q_enq, q_deq, q_repl}, 0);
                step();
            end
            q_rdy = 1'b1;
            #1;
            chk("strobe_sel", {q_enq, q_deq, q_repl},
                {op == ENQ, op == DEQ, op == REPL});
            step();
            chk("wait_no_rsp", rsp_valid, 0);
            chk("wait_no_strobe", {q_enq, q_deq, q_repl}, 0);
            step();
        end
        n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        chk("rsp_latency", n, 0);
        for (int i = 0; i < rsp_hold; i++) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_busy", req_ready, 0);
            chk("hold_data", rsp_data, e_data);
            step();
        end
        rsp_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e[W-1:0]);
            chk("rsp_err", rsp_err, e[W]);
        end
        step();
        rsp_ready = 1'b0;
        chk("back_idle", req_ready, 1);
        chk("rsp_drop", rsp_valid, 0);
        chk("count", count, exp_count);
        chk("n_enq", ne, issue && op == ENQ);
        chk("n_deq", nd, issue && op == DEQ);
        chk("n_repl", nr, issue && op == REPL);
    endtask

    initial begin
        rst = 1'b1;
        #1;
        chk_reset("rst");
        step();
        step();
        rst = 1'b0;
        step();
        chk_reset("post_rst");

        run_op(ENQ, 8'h25, 8'h00, 1'b0, 1'b1, 0, 0);
        run_op(DEQ, 8'h00, 8'h25, 1'b0, 1'b0, 0, 0);
        run_op(ENQ, 8'h30, 8'h00, 1'b0, 1'b1, 0, 0);
        run_op(DEQ, 8'h00, 8'h30, 1'b0, 1'b0, 0, 0);
        run_op(DEQ, 8'h00, 8'h44, 1'b0, 1'b1, 0, 0);
        run_op(ENQ, 8'h05, 8'h00, 1'b0, 1'b1, 0, 0);
        run_op(ENQ, 8'h40, 8'h05, 1'b0, 1'b0, 0, 0);
        run_op(ENQ, 8'h50, 8'h05, 1'b0, 1'b0, 0, 0);
        run_op(ENQ, 8'h60, 8'h05, 1'b0, 1'b0, 0, 0);
        run_op(ENQ, 8'h70, 8'h05, 1'b1, 1'b0, 0, 0);
        run_op(REPL, 8'h11, 8'h05, 1'b1, 1'b0, 0, 0);
        run_op(ENQ, 8'h77, 8'h05, 1'b0, 1'b0, 5, 0);
        run_op(DEQ, 8'h00, 8'h05, 1'b0, 1'b0, 0, 3);
        run_op(REPL, 8'h12, 8'h00, 1'b0, 1'b1, 0, 0);
        run_op(NOP, 8'h9A, 8'hAB, 1'b0, 1'b0, 0, 0);

        // Reset while parked in ISSUE waiting for q_rdy
        ne = 0; nd = 0; nr = 0;
        req_valid = 1'b1;
        req_op    = ENQ;
        req_data  = 8'h66;
        q_rdy     = 1'b0;
        step();
        req_valid = 1'b0;
        chk("mid_in_issue", req_ready, 0);
        rst = 1'b1;
        #1;
        chk_reset("mid_rst");
        q_rdy = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk_reset("mid_after");
        chk("mid_no_strobe", ne + nd + nr, 0);
        exp_count = 0;

`ifdef QQ_HOST_TIMEOUT_EN
        begin
            int n;
            req_valid = 1'b1;
            req_op    = ENQ;
            req_data  = 8'h99;
            q_rdy     = 1'b1;
            q_full    = 1'b0;
            step();
            req_valid = 1'b0;
            step();
            q_rdy = 1'b0;
            n = 1;
            while (!rsp_valid && n < 40) begin
                step();
                n++;
            end
            chk("to_cycle", n, 17);
            chk("to_err", rsp_err, 1);
            chk("to_data", rsp_data, 0);
            chk("to_count", count, 1);
            rsp_ready = 1'b1;
            q_rdy = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk("to_idle", req_ready, 1);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
